seven_segment_capture: RTL and testbench

//  Receive-side counterpart of the multiplexed 7-segment driver: samples the active-low DIGIT strobes and
//  the active-low DISPLAY segment bus, filters out glitches, and decodes each segment pattern back to BCD.

---
 rtl/seven_segment_capture_if.sv | 26 ++
 rtl/seven_segment_capture.sv | 143 ++++++++++++++
 tb/tb_seven_segment_capture.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_capture_if.sv
// Capture-side bundle for the 7-segment loopback monitor.
// Driver side is master, the capture block is slave.
interface seven_segment_capture_if;
  logic [3:0] DIGIT;
  logic [6:0] DISPLAY;
  logic       clear;
  logic [3:0] BCD0;
  logic [3:0] BCD1;
  logic [3:0] BCD2;
  logic [3:0] BCD3;
  logic [3:0] valid;
  logic       frame_done;
  logic       err;

  modport master (
    output DIGIT, DISPLAY, clear,
    input  BCD0, BCD1, BCD2, BCD3,
    input  valid, frame_done, err
  );

  modport slave (
    input  DIGIT, DISPLAY, clear,
    output BCD0, BCD1, BCD2, BCD3,
    output valid, frame_done, err
  );
endinterface

// File: rtl/seven_segment_capture.sv
// Samples multiplexed active-low strobes and segments,
// filters glitches and decodes each digit back to BCD.
module seven_segment_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  seven_segment_capture_if.slave bus
);

  localparam int CW =
    (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(STABLE_CYCLES);
  localparam logic [3:0] POS_MASK =
    4'((1 << NUM_DIGITS) - 1);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  state_t            state_q, state_d;
  logic [10:0]       in_q, in_d;
  logic [CW-1:0]     run_q, run_d;
  logic [3:0][3:0]   bcd_q;
  logic [3:0]        valid_q;
  logic [3:0]        seen_q, seen_d;
  logic              frame_q;
  logic              err_q, err_d;

  logic              chg;
  logic [3:0]        nx_low;
  logic              nx_one;
  logic              nx_multi;
  logic              cur_one;
  logic [1:0]        cur_pos;
  logic              cur_hit;
  logic [3:0]        dec;
  logic              fire;
  logic              commit;
  logic              full;

  // Classify the incoming sample against the held one
  always_comb begin
    in_d     = {bus.DIGIT, bus.DISPLAY};
    chg      = (in_d != in_q);
    nx_low   = ~bus.DIGIT;
    nx_one   = (nx_low != 4'h0) &&
               ((nx_low & (nx_low - 4'h1)) == 4'h0);
    nx_multi = (nx_low != 4'h0) && !nx_one;
  end

  // Position selected by the held strobe
  always_comb begin
    cur_one = 1'b1;
    cur_pos = 2'd0;
    case (in_q[10:7])
      4'b1110: cur_pos = 2'd0;
      4'b1101: cur_pos = 2'd1;
      4'b1011: cur_pos = 2'd2;
      4'b0111: cur_pos = 2'd3;
      default: cur_one = 1'b0;
    endcase
  end

  // Segment pattern {a..g} back to BCD
  always_comb begin
    dec = 4'hE;
    case (in_q[6:0])
      7'b0000001: dec = 4'd0;
      7'b1001111: dec = 4'd1;
      7'b0010010: dec = 4'd2;
      7'b0000110: dec = 4'd3;
      7'b1001100: dec = 4'd4;
      7'b0100100: dec = 4'd5;
      7'b0100000: dec = 4'd6;
      7'b0001111: dec = 4'd7;
      7'b0000000: dec = 4'd8;
      7'b0000100: dec = 4'd9;
      7'b1111111: dec = 4'hF;
      default:    dec = 4'hE;
    endcase
  end

  // Commit decision and next-state terms
  always_comb begin
    cur_hit = cur_one && POS_MASK[cur_pos];
    fire    = (state_q == TRACK) && (run_q == RUN_MAX);
    commit  = fire && cur_hit;
    full    = ((seen_q & POS_MASK) == POS_MASK);

    if (chg)
      run_d = CW'(1);
    else if (run_q == RUN_MAX)
      run_d = run_q;
    else
      run_d = run_q + CW'(1);

    if (chg)
      state_d = nx_one ? TRACK : IDLE;
    else if (fire)
      state_d = HELD;
    else
      state_d = state_q;

    seen_d = (full ? 4'h0 : seen_q) |
             (commit ? (4'b0001 << cur_pos) : 4'h0);
    err_d  = (chg && nx_multi) ||
             (commit && (dec == 4'hE));
  end

  // Capture FSM with registered results
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      state_q <= IDLE;
      in_q    <= '1;
      run_q   <= '0;
      bcd_q   <= {4{4'hF}};
      valid_q <= 4'h0;
      seen_q  <= 4'h0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      run_q   <= run_d;
      seen_q  <= seen_d;
      frame_q <= full;
      err_q   <= err_d;
      if (commit) begin
        bcd_q[cur_pos]   <= dec;
        valid_q[cur_pos] <= 1'b1;
      end
    end
  end

  assign bus.BCD0       = bcd_q[0];
  assign bus.BCD1       = bcd_q[1];
  assign bus.BCD2       = bcd_q[2];
  assign bus.BCD3       = bcd_q[3];
  assign bus.valid      = valid_q;
  assign bus.frame_done = frame_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: two instances
// (STABLE_CYCLES 1 and 3) against a run-length model.
module tb_seven_segment_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit;
  logic [6:0] display;
  logic       clear;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  seven_segment_capture_if bus1 ();
  seven_segment_capture_if bus3 ();

  assign bus1.DIGIT   = digit;
  assign bus1.DISPLAY = display;
  assign bus1.clear   = clear;
  assign bus3.DIGIT   = digit;
  assign bus3.DISPLAY = display;
  assign bus3.clear   = clear;

  seven_segment_capture #(
    .NUM_DIGITS(4), .STABLE_CYCLES(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  seven_segment_capture #(
    .NUM_DIGITS(4), .STABLE_CYCLES(3)
  ) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  logic [25:0] obs [2];
  assign obs[0] = {bus1.BCD3, bus1.BCD2, bus1.BCD1,
                   bus1.BCD0, bus1.valid,
                   bus1.frame_done, bus1.err};
  assign obs[1] = {bus3.BCD3, bus3.BCD2, bus3.BCD1,
                   bus3.BCD0, bus3.valid,
                   bus3.frame_done, bus3.err};

  // reference model state, index 0 -> S=1, 1 -> S=3
  logic [3:0]  m_bcd [2][4];
  logic [3:0]  m_valid [2];
  logic [3:0]  m_seen [2];
  logic        m_fd [2];
  logic        m_err [2];
  logic [10:0] r_val [2];
  int          r_len [2];

  function automatic int sc(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [6:0] seg(int n);
    case (n)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] ref_dec(logic [6:0] s);
    for (int n = 0; n < 10; n++)
      if (seg(n) == s) return 4'(n);
    if (s == 7'b1111111) return 4'hF;
    return 4'hE;
  endfunction

  function automatic logic [25:0] ex(int k);
    return {m_bcd[k][3], m_bcd[k][2], m_bcd[k][1],
            m_bcd[k][0], m_valid[k], m_fd[k], m_err[k]};
  endfunction

  // one clock edge of the model: a run of identical
  // samples commits at the edge after its S-th sample
  task automatic model_edge();
    logic [10:0] s;
    logic [3:0]  d;
    logic [3:0]  dv;
    int          p;
    logic        e;
    for (int k = 0; k < 2; k++) begin
      if (rst || clear) begin
        for (int i = 0; i < 4; i++) m_bcd[k][i] = 4'hF;
        m_valid[k] = 4'h0;
        m_seen[k]  = 4'h0;
        m_fd[k]    = 1'b0;
        m_err[k]   = 1'b0;
        r_val[k]   = '1;
        r_len[k]   = 0;
      end else begin
        s = {digit, display};
        e = 1'b0;
        m_fd[k] = (m_seen[k] == 4'hF);
        if (m_fd[k]) m_seen[k] = 4'h0;
        d = r_val[k][10:7];
        if (r_len[k] == sc(k) && $countones(~d) == 1) begin
          p = 0;
          for (int i = 0; i < 4; i++) if (!d[i]) p = i;
          dv = ref_dec(r_val[k][6:0]);
          m_bcd[k][p]   = dv;
          m_valid[k][p] = 1'b1;
          m_seen[k][p]  = 1'b1;
          if (dv == 4'hE) e = 1'b1;
        end
        if (s == r_val[k]) begin
          r_len[k]++;
        end else begin
          r_val[k] = s;
          r_len[k] = 1;
          if ($countones(~s[10:7]) >= 2) e = 1'b1;
        end
        m_err[k] = e;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(logic [3:0] dg, logic [6:0] ds);
    digit   = dg;
    display = ds;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear = 1'b0;
    drive(4'b0000, 7'b0000000);
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== {16'hFFFF, 4'h0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL reset k=%0d got=%h want=%h",
                 k, obs[k], {16'hFFFF, 6'h0});
      end
    end
    drive(4'b1111, 7'b1111111);
    rst = 1'b0;
  endtask

  task automatic test_loopback();
    logic [3:0] dg [4];
    logic [6:0] ds [4];
    dg = '{4'b1111, 4'b1111, 4'b1101, 4'b1110};
    ds = '{7'b1111111, 7'b1111111, seg(3), seg(7)};
    for (int r = 0; r < 5; r++) begin
      for (int s = 0; s < 4; s++) begin
        drive(dg[s], ds[s]);
        tick();
        for (int k = 0; k < 2; k++) begin
          total++;
          if (obs[k] !== ex(k)) begin
            bad++;
            $display("FAIL loopback k=%0d got=%h want=%h",
                     k, obs[k], ex(k));
          end
        end
        total++;
        if (bus1.err !== 1'b0) begin
          bad++;
          $display("FAIL loopback_err got=%b want=0",
                   bus1.err);
        end
      end
    end
    drive(4'b1111, 7'b1111111);
    repeat (2) tick();
    total++;
    if ({bus1.BCD1, bus1.BCD0, bus1.valid} !==
        {4'd3, 4'd7, 4'b0011}) begin
      bad++;
      $display("FAIL loopback_val got=%h%h/%b want=37/0011",
               bus1.BCD1, bus1.BCD0, bus1.valid);
    end
  endtask

  task automatic test_stable();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drive(4'b1110, seg(2));
    tick();
    drive(4'b1111, 7'b1111111);
    repeat (4) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== ex(k)) begin
          bad++;
          $display("FAIL stable k=%0d got=%h want=%h",
                   k, obs[k], ex(k));
        end
      end
    end
    total++;
    if (bus3.valid !== 4'h0) begin
      bad++;
      $display("FAIL short_hold got=%b want=0000",
               bus3.valid);
    end
    drive(4'b1110, seg(2));
    repeat (3) tick();
    total++;
    if (bus3.BCD0 !== 4'hF) begin
      bad++;
      $display("FAIL early_commit got=%h want=f", bus3.BCD0);
    end
    drive(4'b1111, 7'b1111111);
    tick();
    total++;
    if ({bus3.BCD0, bus3.valid} !== {4'd2, 4'b0001}) begin
      bad++;
      $display("FAIL s3_commit got=%h/%b want=2/0001",
               bus3.BCD0, bus3.valid);
    end
  endtask

  task automatic test_illegal();
    int e1;
    int e3;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    e1 = 0;
    e3 = 0;
    drive(4'b1101, 7'b1111110);
    repeat (4) begin
      tick();
      e1 += int'(bus1.err);
      e3 += int'(bus3.err);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== ex(k)) begin
          bad++;
          $display("FAIL illegal k=%0d got=%h want=%h",
                   k, obs[k], ex(k));
        end
      end
    end
    total++;
    if (e1 != 1 || e3 != 1) begin
      bad++;
      $display("FAIL pat_err got=%0d/%0d want=1/1", e1, e3);
    end
    total++;
    if ({bus1.BCD1, bus1.valid[1]} !== {4'hE, 1'b1}) begin
      bad++;
      $display("FAIL pat_bcd got=%h/%b want=e/1",
               bus1.BCD1, bus1.valid[1]);
    end
    e1 = 0;
    e3 = 0;
    drive(4'b1100, seg(5));
    repeat (3) begin
      tick();
      e1 += int'(bus1.err);
      e3 += int'(bus3.err);
    end
    total++;
    if (e1 != 1 || e3 != 1) begin
      bad++;
      $display("FAIL strobe_err got=%0d/%0d want=1/1", e1, e3);
    end
    total++;
    if ({bus1.BCD3, bus1.BCD2, bus1.BCD1, bus1.BCD0} !==
        16'hFFEF) begin
      bad++;
      $display("FAIL strobe_bcd got=%h%h%h%h want=ffef",
               bus1.BCD3, bus1.BCD2, bus1.BCD1, bus1.BCD0);
    end
  endtask

  task automatic test_frame();
    int fd;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    fd = 0;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 4; p++) begin
        drive(~(4'b0001 << p), seg(p + 1));
        tick();
        fd += int'(bus1.frame_done);
        for (int k = 0; k < 2; k++) begin
          total++;
          if (obs[k] !== ex(k)) begin
            bad++;
            $display("FAIL frame k=%0d got=%h want=%h",
                     k, obs[k], ex(k));
          end
        end
      end
    end
    drive(4'b1111, 7'b1111111);
    repeat (3) begin
      tick();
      fd += int'(bus1.frame_done);
    end
    total++;
    if (fd != 3) begin
      bad++;
      $display("FAIL frame_count got=%0d want=3", fd);
    end
    total++;
    if ({bus1.BCD3, bus1.BCD2, bus1.BCD1, bus1.BCD0,
         bus1.valid} !== {16'h4321, 4'hF}) begin
      bad++;
      $display("FAIL frame_bcd got=%h%h%h%h/%b want=4321/1111",
               bus1.BCD3, bus1.BCD2, bus1.BCD1, bus1.BCD0,
               bus1.valid);
    end
  endtask

  task automatic test_clear();
    drive(4'b1110, seg(8));
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drive(4'b1111, 7'b1111111);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== {16'hFFFF, 6'h0}) begin
        bad++;
        $display("FAIL clear k=%0d got=%h want=%h",
                 k, obs[k], {16'hFFFF, 6'h0});
      end
    end
    repeat (2) tick();
    total++;
    if ({bus1.BCD0, bus1.valid} !== {4'hF, 4'h0}) begin
      bad++;
      $display("FAIL clear_pending got=%h/%b want=f/0000",
               bus1.BCD0, bus1.valid);
    end
  endtask

  task automatic test_random();
    int         hold;
    int         r;
    logic [3:0] dg;
    logic [6:0] ds;
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3) dg = 4'b1111;
      else if (r < 9) dg = ~(4'b0001 << $urandom_range(0, 3));
      else dg = 4'($urandom);
      if ($urandom_range(0, 4) == 0) ds = 7'($urandom);
      else ds = seg($urandom_range(0, 10));
      drive(dg, ds);
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        clear = ($urandom_range(0, 60) == 0);
        tick();
        clear = 1'b0;
        for (int k = 0; k < 2; k++) begin
          total++;
          if (obs[k] !== ex(k)) begin
            bad++;
            $display("FAIL random k=%0d n=%0d got=%h want=%h",
                     k, n, obs[k], ex(k));
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    digit = 4'b1111;
    display = 7'b1111111;
    @(negedge clk);
    test_reset();
    test_loopback();
    test_stable();
    test_illegal();
    test_frame();
    test_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
